rgb565_fb_writer: RTL and testbench
===================================

Name: rgb565_fb_writer

Overview:
- Downstream of the RGB888→RGB565 pixel conversion stage; consumes its `wFgRgb565Valid`/`wRgb565` stream.
- Writes one frame of RGB565 pixels into a double-banked frame-buffer RAM (bank bit is the address MSB).
- Publishes which bank holds the latest complete frame for the display/readout side.
- Tracks frame framing errors: stray pixels and short frames.

Parameters:
- H_ACT, 480, active pixels per line
- V_ACT, 272, active lines per frame
- ADDR_W, 17, per-bank address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT

Ports:
- iClk  in  1  system clock
- wRsn  in  1  reset; asynchronous, active-low
- wEnClk  in  1  pixel-rate enable (25 MHz strobe)
- wStFrame  in  1  start-of-frame pulse; sampled only when wEnClk=1
- wFgRgb565Valid  in  1  upstream pixel valid (level)
- wRgb565  in  16  upstream pixel {R5,G6,B5}
- wRdBusy  in  1  reader currently scanning wRdBank
- wErrClr  in  1  clears sticky error flags
- wRamWe  out  1  RAM write strobe, one iClk wide
- wRamAddr  out  ADDR_W+1  {bank, linear pixel index}
- wRamWrData  out  16  RAM write data
- wFrameDone  out  1  one-iClk pulse after the last pixel of a frame is written
- wRdBank  out  1  bank holding the latest complete frame
- wRdBankValid  out  1  at least one complete frame exists
- wErrOvf  out  1  sticky: pixel arrived outside an accepting frame
- wErrShort  out  1  sticky: SOF arrived before the frame completed

Behaviour:
- Reset values: all outputs 0; state IDLE; write bank 0; counters 0.
- An input event exists only on iClk edges with wEnClk=1. A pixel = wEnClk & wFgRgb565Valid. An SOF = wEnClk & wStFrame.
- States: IDLE, WRITE, DROP, DONE.
- IDLE:
  - SOF with wRdBusy=0 → WRITE; x, y and linear address cleared.
  - SOF with wRdBusy=1 → DROP.
  - Pixel without SOF → ignored; wErrOvf set.
- WRITE:
  - Each pixel is registered. The next iClk drives wRamWe=1, wRamAddr={wrBank, addr}, wRamWrData=pixel. Latency is exactly 1 iClk.
  - addr increments by 1 per pixel. x wraps at H_ACT-1 to 0 and increments y. No multiplier; linear counter only.
  - The pixel at x=H_ACT-1, y=V_ACT-1 is the last one → DONE.
  - SOF before the last pixel → wErrShort set, counters restart at 0 in the same bank, stay in WRITE.
- DONE (exactly 1 iClk, independent of wEnClk):
  - wFrameDone=1; wRdBank<=wrBank; wRdBankValid<=1; wrBank<=~wrBank; → IDLE.
  - The last wRamWe precedes wFrameDone by 1 iClk.
- DROP:
  - Pixels are discarded with no RAM write and no error.
  - Next SOF re-evaluates wRdBusy exactly as in IDLE.
  - wrBank is unchanged.
- Rationale for DROP: after a swap, the new write bank is the old read bank. Blocking at SOF while wRdBusy is high prevents tearing under the reader.
- SOF and pixel in the same enabled cycle: SOF is applied first, and that pixel is written as addr 0 of the new frame. This holds from IDLE, WRITE (restart) and DROP → WRITE.
- A pixel landing on the DONE cycle cannot occur when wEnClk is at most one iClk in two. If wEnClk is continuously high, such a pixel is dropped and wErrOvf is set.
- wErrClr clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- wRamWe is never asserted in IDLE, DROP or DONE. Address never exceeds H_ACT*V_ACT-1 within a bank.
- Reset mid-frame: immediate return to reset values; any partial frame is abandoned and wRdBankValid=0.

Decomposition:
- Package `fb_writer_pkg`: state encoding (IDLE/WRITE/DROP/DONE), default H_ACT/V_ACT/ADDR_W constants, RGB565 width constant.
- One sub-module: `fb_addr_counter`. It holds x/y/linear counters with clear, increment and last-pixel flag, parameterised by H_ACT/V_ACT/ADDR_W.
- The FSM, bank logic, output registers and error flags live in the top.

Test Plan:
All scenarios use H_ACT=4, V_ACT=2, wEnClk high every 2nd iClk.
- Full frame: SOF, then 8 pixels 0x0001..0x0008 → 8 wRamWe at addr {0,0..7} with matching data. wFrameDone 1 iClk after the 8th write; wRdBank=0, wRdBankValid=1.
- Second frame: SOF, then 8 pixels → writes at {1,0..7}; after done, wRdBank=1.
- Short frame: SOF, 3 pixels, SOF, 8 pixels → wErrShort=1. Second frame writes addr 0..7 in the same bank. Exactly one wFrameDone.
- Reader busy: wRdBusy=1 at SOF → 8 pixels produce no wRamWe and no wFrameDone. Next SOF with wRdBusy=0 writes normally, in the same bank as before.
- Stray/simultaneous: pixel in IDLE → wErrOvf=1. SOF plus pixel 0xABCD in the same enable → write {bank,0}=0xABCD. wErrClr → both flags 0.
- Reset: assert wRsn low after 5 pixels → all outputs 0 immediately. Next full frame writes bank 0 from addr 0.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared constants for the RGB565 frame-buffer writer: FSM encoding and default geometry.
package fb_writer_pkg;

  localparam int unsigned H_ACT_DEF  = 480;
  localparam int unsigned V_ACT_DEF  = 272;
  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned RGB565_W   = 16;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_WRITE = 2'd1;
  localparam logic [ST_W-1:0] ST_DROP  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fb_addr_counter.sv
// x/y/linear pixel counters for one frame; clear and increment may coincide (clear first).
module fb_addr_counter
  import fb_writer_pkg::*;
#(
  parameter int unsigned H_ACT  = H_ACT_DEF,
  parameter int unsigned V_ACT  = V_ACT_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr_c,
  output logic              last_c
);

  localparam int unsigned X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  logic [X_W-1:0]    x_q, x_d, x_base;
  logic [Y_W-1:0]    y_q, y_d, y_base;
  logic [ADDR_W-1:0] a_q, a_d, a_base;
  logic              x_end;

  // Base values describe the pixel being accepted this cycle.
  always_comb begin
    x_base = clr ? '0 : x_q;
    y_base = clr ? '0 : y_q;
    a_base = clr ? '0 : a_q;
    x_end  = (x_base == X_W'(H_ACT - 1));
    last_c = x_end && (y_base == Y_W'(V_ACT - 1));
    addr_c = a_base;

    x_d = x_base;
    y_d = y_base;
    a_d = a_base;
    if (inc) begin
      if (x_end) begin
        x_d = '0;
        y_d = last_c ? '0 : y_base + Y_W'(1);
      end else begin
        x_d = x_base + X_W'(1);
      end
      a_d = last_c ? '0 : a_base + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      a_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      a_q <= a_d;
    end
  end

endmodule

// File: rtl/rgb565_fb_writer.sv
// Writes one RGB565 frame per SOF into a double-banked RAM and publishes the latest complete bank.
module rgb565_fb_writer
  import fb_writer_pkg::*;
#(
  parameter int unsigned H_ACT  = H_ACT_DEF,
  parameter int unsigned V_ACT  = V_ACT_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                iClk,
  input  logic                wRsn,
  input  logic                wEnClk,
  input  logic                wStFrame,
  input  logic                wFgRgb565Valid,
  input  logic [RGB565_W-1:0] wRgb565,
  input  logic                wRdBusy,
  input  logic                wErrClr,
  output logic                wRamWe,
  output logic [ADDR_W:0]     wRamAddr,
  output logic [RGB565_W-1:0] wRamWrData,
  output logic                wFrameDone,
  output logic                wRdBank,
  output logic                wRdBankValid,
  output logic                wErrOvf,
  output logic                wErrShort
);

  logic [ST_W-1:0]     state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                rd_valid_q, rd_valid_d;
  logic                we_q, we_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [RGB565_W-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                short_q, short_d;

  logic                pixel, sof, accept;
  logic                cnt_clr, cnt_inc;
  logic                ovf_evt, short_evt;
  logic [ADDR_W-1:0]   pix_addr_c;
  logic                pix_last_c;

  assign pixel = wEnClk & wFgRgb565Valid;
  assign sof   = wEnClk & wStFrame;

  fb_addr_counter #(
    .H_ACT  (H_ACT),
    .V_ACT  (V_ACT),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk    (iClk),
    .rst_n  (wRsn),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .addr_c (pix_addr_c),
    .last_c (pix_last_c)
  );

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_valid_d = rd_valid_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    cnt_clr    = 1'b0;
    ovf_evt    = 1'b0;
    short_evt  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DROP: begin
        // SOF is re-evaluated against the reader here so we never write under it.
        if (sof) begin
          if (!wRdBusy) begin
            state_d = ST_WRITE;
            cnt_clr = 1'b1;
            accept  = pixel;
          end else begin
            state_d = ST_DROP;
          end
        end else if (pixel && (state_q == ST_IDLE)) begin
          ovf_evt = 1'b1;
        end
      end
      ST_WRITE: begin
        if (sof) begin
          short_evt = 1'b1;
          cnt_clr   = 1'b1;
        end
        accept = pixel;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        rd_bank_d  = wr_bank_q;
        rd_valid_d = 1'b1;
        wr_bank_d  = ~wr_bank_q;
        state_d    = ST_IDLE;
        ovf_evt    = pixel;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_inc = accept;
    if (accept) begin
      we_d   = 1'b1;
      addr_d = {wr_bank_q, pix_addr_c};
      data_d = wRgb565;
      if (pix_last_c) state_d = ST_DONE;
    end

    // A same-cycle error event wins over the clear.
    ovf_d   = (ovf_q & ~wErrClr) | ovf_evt;
    short_d = (short_q & ~wErrClr) | short_evt;
  end

  always_ff @(posedge iClk or negedge wRsn) begin
    if (!wRsn) begin
      state_q    <= ST_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      short_q    <= short_d;
    end
  end

  assign wRamWe       = we_q;
  assign wRamAddr     = addr_q;
  assign wRamWrData   = data_q;
  assign wFrameDone   = done_q;
  assign wRdBank      = rd_bank_q;
  assign wRdBankValid = rd_valid_q;
  assign wErrOvf      = ovf_q;
  assign wErrShort    = short_q;

endmodule

// File: tb/tb_rgb565_fb_writer.sv
// Directed bench for rgb565_fb_writer with a 4x2 frame and a pixel enable every second clock.
module tb_rgb565_fb_writer;

  logic        iClk = 1'b0;
  logic        wRsn;
  logic        wEnClk;
  logic        wStFrame;
  logic        wFgRgb565Valid;
  logic [15:0] wRgb565;
  logic        wRdBusy;
  logic        wErrClr;
  logic        wRamWe;
  logic [3:0]  wRamAddr;
  logic [15:0] wRamWrData;
  logic        wFrameDone;
  logic        wRdBank;
  logic        wRdBankValid;
  logic        wErrOvf;
  logic        wErrShort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [3:0]  wa_log[$];
  logic [15:0] wd_log[$];

  rgb565_fb_writer #(.H_ACT(4), .V_ACT(2), .ADDR_W(3)) dut (
    .iClk           (iClk),
    .wRsn           (wRsn),
    .wEnClk         (wEnClk),
    .wStFrame       (wStFrame),
    .wFgRgb565Valid (wFgRgb565Valid),
    .wRgb565        (wRgb565),
    .wRdBusy        (wRdBusy),
    .wErrClr        (wErrClr),
    .wRamWe         (wRamWe),
    .wRamAddr       (wRamAddr),
    .wRamWrData     (wRamWrData),
    .wFrameDone     (wFrameDone),
    .wRdBank        (wRdBank),
    .wRdBankValid   (wRdBankValid),
    .wErrOvf        (wErrOvf),
    .wErrShort      (wErrShort)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Log every RAM write and frame-done pulse, sampled mid-cycle.
  always @(negedge iClk) begin
    if (wRamWe === 1'b1) begin
      wa_log.push_back(wRamAddr);
      wd_log.push_back(wRamWrData);
      last_we_cyc = cyc;
    end
    if (wFrameDone === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  // One enabled cycle followed by one disabled cycle; returns just after the enabled edge.
  task automatic pix_step(input logic sof, input logic vld, input logic [15:0] d);
    @(posedge iClk);
    #1;
    wEnClk = 1'b1; wStFrame = sof; wFgRgb565Valid = vld; wRgb565 = d;
    @(posedge iClk);
    #1;
    wEnClk = 1'b0; wStFrame = 1'b0; wFgRgb565Valid = 1'b0;
  endtask

  task automatic pixels(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) pix_step(1'b0, 1'b1, base + 16'(i));
  endtask

  task automatic chk_writes(input string tag, input int idx, input int n,
                            input logic bank, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 32'(wa_log[idx+i]), 32'({bank, 3'(i)}));
      check({tag, "_data"}, 32'(wd_log[idx+i]), 32'(base + 16'(i)));
    end
  endtask

  initial begin
    int w0;
    int d0;
    wRsn = 1'b0; wEnClk = 1'b0; wStFrame = 1'b0; wFgRgb565Valid = 1'b0;
    wRgb565 = '0; wRdBusy = 1'b0; wErrClr = 1'b0;
    idle(3);
    check("reset_outputs", 32'({wRamWe, wRamAddr, wRamWrData, wFrameDone, wRdBank,
                                wRdBankValid, wErrOvf, wErrShort}), 32'd0);
    wRsn = 1'b1;
    idle(2);

    // Full frame into bank 0
    w0 = wa_log.size(); d0 = done_cnt;
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0001);
    idle(3);
    check("f1_nwrites", 32'(wa_log.size() - w0), 32'd8);
    chk_writes("f1", w0, 8, 1'b0, 16'h0001);
    check("f1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("f1_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
    check("f1_rdbank", 32'(wRdBank), 32'd0);
    check("f1_rdvalid", 32'(wRdBankValid), 32'd1);

    // Second frame into bank 1
    w0 = wa_log.size(); d0 = done_cnt;
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0101);
    idle(3);
    check("f2_nwrites", 32'(wa_log.size() - w0), 32'd8);
    chk_writes("f2", w0, 8, 1'b1, 16'h0101);
    check("f2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("f2_rdbank", 32'(wRdBank), 32'd1);

    // Short frame then complete frame, both in bank 0
    w0 = wa_log.size(); d0 = done_cnt;
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(3, 16'h0201);
    check("sh_no_err_yet", 32'(wErrShort), 32'd0);
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0301);
    idle(3);
    check("sh_err", 32'(wErrShort), 32'd1);
    check("sh_nwrites", 32'(wa_log.size() - w0), 32'd11);
    chk_writes("sh_part", w0, 3, 1'b0, 16'h0201);
    chk_writes("sh_full", w0 + 3, 8, 1'b0, 16'h0301);
    check("sh_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("sh_rdbank", 32'(wRdBank), 32'd0);

    // Reader busy: frame dropped, then written into bank 1
    w0 = wa_log.size(); d0 = done_cnt;
    wRdBusy = 1'b1;
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0401);
    idle(3);
    check("busy_nwrites", 32'(wa_log.size() - w0), 32'd0);
    check("busy_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("busy_no_ovf", 32'(wErrOvf), 32'd0);
    wRdBusy = 1'b0;
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0501);
    idle(3);
    check("busy2_nwrites", 32'(wa_log.size() - w0), 32'd8);
    chk_writes("busy2", w0, 8, 1'b1, 16'h0501);
    check("busy2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("busy2_rdbank", 32'(wRdBank), 32'd1);

    // Stray pixel in IDLE, then SOF with a pixel on the same enable (bank 0)
    w0 = wa_log.size();
    pix_step(1'b0, 1'b1, 16'h1234);
    idle(1);
    check("stray_ovf", 32'(wErrOvf), 32'd1);
    check("stray_nwrites", 32'(wa_log.size() - w0), 32'd0);
    pix_step(1'b1, 1'b1, 16'hABCD);
    check("simul_we", 32'(wRamWe), 32'd1);
    check("simul_addr", 32'(wRamAddr), 32'h0);
    check("simul_data", 32'(wRamWrData), 32'hABCD);
    wErrClr = 1'b1;
    idle(1);
    wErrClr = 1'b0;
    check("clr_flags", 32'({wErrOvf, wErrShort}), 32'd0);

    // Reset mid-frame
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(5, 16'h0601);
    check("pre_rst_we", 32'(wRamWe), 32'd1);
    wRsn = 1'b0;
    #1;
    check("rst_outputs", 32'({wRamWe, wRamAddr, wRamWrData, wFrameDone, wRdBank,
                              wRdBankValid, wErrOvf, wErrShort}), 32'd0);
    idle(2);
    wRsn = 1'b1;
    idle(2);
    w0 = wa_log.size(); d0 = done_cnt;
    pix_step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0701);
    idle(3);
    check("postrst_nwrites", 32'(wa_log.size() - w0), 32'd8);
    chk_writes("postrst", w0, 8, 1'b0, 16'h0701);
    check("postrst_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("postrst_rdbank", 32'(wRdBank), 32'd0);
    check("postrst_rdvalid", 32'(wRdBankValid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
